instruction_decode: RTL and testbench
=====================================

# instruction_decode

Decode stage directly downstream of the instruction fetch bank. It consumes the bank's word stream, removes duplicate presentations and assembles two-word ShapeSet instructions. It buffers decoded instructions in a FIFO for the execute/render stage, and drives the bank's `action` and `dIType` feedback inputs.

## Interface
- `INSTRUCTION_WIDTH`, 32: fetched word width (`proctypes`).
- `DEPTH`, 8: decoded-instruction FIFO entries; power of two, ≥4.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instruction_valid`  in  1  fetch word valid.
- `pc_in`  in  InstructionAddr  address of the fetch word.
- `inst`  in  INSTRUCTION_WIDTH  fetch word.
- `action`  out  FetchAction  `fetchDequeue` / `fetchStall` to fetch.
- `dIType`  out  InstructionType  `opShapeSet` while the next accepted word is a ShapeSet data word.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head when `out_valid` is high.
- `out_itype`  out  InstructionType  head type.
- `out_pc`  out  InstructionAddr  head header address.
- `out_header`, `out_data`  out  INSTRUCTION_WIDTH each  header word; data word (0 unless ShapeSet).
- `halted`  out  1  End decoded; fetch frozen.
- `err_overflow`  out  1  sticky; a word arrived with the FIFO full.

## Operation
- Classify each header word:
  - all-zero word → `opEnd`.
  - `32'h0000_0600` → `opLoop`.
  - `inst[2:0]`=1 → `opShapeSet`.
  - 2 → `opCameraSet`.
  - 3 → `opLightSet`.
  - 4 → `opRender`.
  - Anything else → `opInvalid`, forwarded unchanged.
- Dedupe:
  - A word is accepted iff `instruction_valid` and (`last_pc_vld`=0 or `pc_in`≠`last_pc`).
  - On accept, `last_pc`←`pc_in` and `last_pc_vld`←1.
  - Fetch presents each address on two consecutive cycles; the second presentation is dropped.
- Assembler FSM, states `S_HEADER`, `S_DATA`, `S_HALT`:
  - `S_HEADER` + accept:
    - ShapeSet: latch header and `pc_in` → `S_DATA`.
    - opLoop: not pushed; clear `last_pc_vld`; stay.
    - opEnd: push → `S_HALT`.
    - Other types: push with data=0.
  - `S_DATA` + accept: the word is data regardless of value, including zero. Push {opShapeSet, header pc, header, word} → `S_HEADER`.
  - `S_HALT`: words are ignored. Only reset exits this state.
- `dIType` = `opShapeSet` in `S_DATA`, else `opRender` (registered).
- Credit rule: `action`=`fetchDequeue` iff state≠`S_HALT` and FIFO count ≤ DEPTH−3; else `fetchStall`. Three free slots cover the fetch pipeline's in-flight words.
- FIFO: registered, first-word-fall-through head.
  - Simultaneous push and pop on a full FIFO is allowed; count is unchanged.
  - A push with the FIFO full and no pop drops the word and sets `err_overflow`.
- `halted`=1 in `S_HALT`. The FIFO keeps draining while halted.

## Timing
- Reset (async assert, sync-released deassert internally) forces:
  - `action`=`fetchStall`, `dIType`=`opRender`
  - `out_valid`=0, all out data 0
  - `halted`=0, `err_overflow`=0
  - FSM=`S_HEADER`, FIFO empty, `last_pc_vld`=0
- First cycle after reset: `action`=`fetchDequeue`.
- Single-word instruction accepted at edge N with FIFO empty → `out_valid`=1 after edge N+1.
- ShapeSet data accepted at edge M → `out_valid` after edge M+1.
- Pop occurs on the edge where `out_valid`&`out_ready`. The next head is visible after that edge.
- `action` is registered: the credit decision at edge N reflects the count before edge N.
- Reset mid-ShapeSet discards the held header. Reset while halted returns to `S_HEADER`.

## Configuration
- `INSTRUCTION_DECODE_STATS_EN` defined:
  - adds output `stat_decoded` (32 b), incremented per push and saturating at all-ones;
  - adds output `stat_stall` (32 b), incremented per cycle with `action`=`fetchStall` and state≠`S_HALT`;
  - both counters reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Stream of words 0x2 at pc0 and 0x4 at pc1, each presented twice → two pushes only: opCameraSet pc0, then opRender pc1.
- ShapeSet header 0x1 at pc2, then data 0x0 at pc3 → one entry {opShapeSet, pc2, 0x1, 0x0}. `dIType`=`opShapeSet` for exactly the cycles in `S_DATA`.
- `out_ready`=0 with continuous valid words, DEPTH=8 → `action` drops to `fetchStall` once count reaches 6. FIFO peaks ≤8 and `err_overflow` stays 0.
- opLoop word 0x600 at pc5, then pc1 re-presented → 0x600 not pushed; pc1 accepted again after `last_pc_vld` is cleared.
- Word 0x0 in `S_HEADER` → opEnd pushed; `halted`=1 and `action`=`fetchStall` from then on; later words ignored. `rst` low then high → reset values restored.
- With `INSTRUCTION_DECODE_STATS_EN`: 5 decoded instructions and 3 non-halt stall cycles → `stat_decoded`=5, `stat_stall`=3.

Source files
------------

// File: rtl/instruction_decode.sv
// instruction_decode: dedupes the fetch word stream, assembles two-word
// ShapeSet instructions and queues decoded instructions for execute.
// Optional statistics counters: define INSTRUCTION_DECODE_STATS_EN.

package instruction_decode_pkg;

  localparam int unsigned ITYPE_W = 3;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [ITYPE_W-1:0] {
    opInvalid   = 3'd0,
    opShapeSet  = 3'd1,
    opCameraSet = 3'd2,
    opLightSet  = 3'd3,
    opRender    = 3'd4,
    opLoop      = 3'd5,
    opEnd       = 3'd6
  } instruction_type_e;

  typedef enum logic {
    fetchStall   = 1'b0,
    fetchDequeue = 1'b1
  } fetch_action_e;

endpackage

module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned DEPTH             = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instruction_valid,
  input  logic [ADDR_W-1:0]            pc_in,
  input  logic [INSTRUCTION_WIDTH-1:0] inst,
  output logic                         action,
  output logic [ITYPE_W-1:0]           dIType,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ITYPE_W-1:0]           out_itype,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [INSTRUCTION_WIDTH-1:0] out_header,
  output logic [INSTRUCTION_WIDTH-1:0] out_data,
  output logic                         halted,
  output logic                         err_overflow
`ifdef INSTRUCTION_DECODE_STATS_EN
  ,
  output logic [31:0]                  stat_decoded,
  output logic [31:0]                  stat_stall
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH - 3);
  localparam logic [INSTRUCTION_WIDTH-1:0] LOOP_WORD = INSTRUCTION_WIDTH'(32'h0000_0600);

  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_DATA   = 2'd1,
    S_HALT   = 2'd2
  } state_e;

  logic [1:0] rst_sync;
  logic       rst_n;

  state_e                         state;
  logic [ADDR_W-1:0]              last_pc;
  logic                           last_pc_vld;
  logic [INSTRUCTION_WIDTH-1:0]   hdr_word;
  logic [ADDR_W-1:0]              hdr_pc;

  logic                           pend_vld;
  logic [ITYPE_W-1:0]             pend_itype;
  logic [ADDR_W-1:0]              pend_pc;
  logic [INSTRUCTION_WIDTH-1:0]   pend_header;
  logic [INSTRUCTION_WIDTH-1:0]   pend_data;

  logic [ITYPE_W-1:0]             mem_itype  [DEPTH];
  logic [ADDR_W-1:0]              mem_pc     [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0]   mem_header [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0]   mem_data   [DEPTH];
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic [CNT_W-1:0]               count;

  instruction_type_e              cls_c;
  logic                           accept_c;
  logic                           halt_nxt_c;
  logic                           credit_ok_c;
  logic                           pop_c;
  logic                           wr_c;
  logic                           ovf_c;
  logic [CNT_W-1:0]               count_nxt_c;

  // Asynchronous assert, synchronous release of the internal reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Classify the incoming word as an instruction header
  always_comb begin
    cls_c = opInvalid;
    if (inst == '0) begin
      cls_c = opEnd;
    end else if (inst == LOOP_WORD) begin
      cls_c = opLoop;
    end else begin
      case (inst[2:0])
        3'd1:    cls_c = opShapeSet;
        3'd2:    cls_c = opCameraSet;
        3'd3:    cls_c = opLightSet;
        3'd4:    cls_c = opRender;
        default: cls_c = opInvalid;
      endcase
    end
  end

  assign accept_c    = instruction_valid && (state != S_HALT) &&
                       (!last_pc_vld || (pc_in != last_pc));
  assign halt_nxt_c  = (state == S_HALT) ||
                       (accept_c && (state == S_HEADER) && (cls_c == opEnd));
  assign credit_ok_c = (count <= CREDIT_MAX);

  // Assembler FSM, dedupe tracking, decode stage register and fetch feedback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HEADER;
      last_pc     <= '0;
      last_pc_vld <= 1'b0;
      hdr_word    <= '0;
      hdr_pc      <= '0;
      pend_vld    <= 1'b0;
      pend_itype  <= '0;
      pend_pc     <= '0;
      pend_header <= '0;
      pend_data   <= '0;
      dIType      <= opRender;
      action      <= fetchStall;
      halted      <= 1'b0;
    end else begin
      pend_vld <= 1'b0;
      if (accept_c) begin
        last_pc     <= pc_in;
        last_pc_vld <= 1'b1;
        case (state)
          S_HEADER: begin
            case (cls_c)
              opShapeSet: begin
                hdr_word <= inst;
                hdr_pc   <= pc_in;
                state    <= S_DATA;
                dIType   <= opShapeSet;
              end
              opLoop: begin
                last_pc_vld <= 1'b0;
              end
              opEnd: begin
                pend_vld    <= 1'b1;
                pend_itype  <= opEnd;
                pend_pc     <= pc_in;
                pend_header <= inst;
                pend_data   <= '0;
                state       <= S_HALT;
                halted      <= 1'b1;
              end
              default: begin
                pend_vld    <= 1'b1;
                pend_itype  <= cls_c;
                pend_pc     <= pc_in;
                pend_header <= inst;
                pend_data   <= '0;
              end
            endcase
          end
          S_DATA: begin
            pend_vld    <= 1'b1;
            pend_itype  <= opShapeSet;
            pend_pc     <= hdr_pc;
            pend_header <= hdr_word;
            pend_data   <= inst;
            state       <= S_HEADER;
            dIType      <= opRender;
          end
          default: ;
        endcase
      end
      action <= (!halt_nxt_c && credit_ok_c) ? fetchDequeue : fetchStall;
    end
  end

  assign pop_c = out_valid && out_ready;
  assign wr_c  = pend_vld && ((count != FULL_CNT) || pop_c);
  assign ovf_c = pend_vld && (count == FULL_CNT) && !pop_c;

  // Occupancy after this edge's push/pop
  always_comb begin
    count_nxt_c = count;
    case ({wr_c, pop_c})
      2'b10:   count_nxt_c = count + CNT_W'(1);
      2'b01:   count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Decoded-instruction FIFO with first-word-fall-through head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_itype[i]  <= '0;
        mem_pc[i]     <= '0;
        mem_header[i] <= '0;
        mem_data[i]   <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_c) begin
        mem_itype[wr_ptr]  <= pend_itype;
        mem_pc[wr_ptr]     <= pend_pc;
        mem_header[wr_ptr] <= pend_header;
        mem_data[wr_ptr]   <= pend_data;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt_c;
      out_valid <= (count_nxt_c != '0);
      if (ovf_c) err_overflow <= 1'b1;
    end
  end

  assign out_itype  = mem_itype[rd_ptr];
  assign out_pc     = mem_pc[rd_ptr];
  assign out_header = mem_header[rd_ptr];
  assign out_data   = mem_data[rd_ptr];

`ifdef INSTRUCTION_DECODE_STATS_EN
  // Push count (saturating) and non-halt stall cycles, tracked with the action register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded <= '0;
      stat_stall   <= '0;
    end else begin
      if (wr_c && (stat_decoded != '1)) stat_decoded <= stat_decoded + 32'd1;
      if (!halt_nxt_c && !credit_ok_c)   stat_stall   <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode.
module tb_instruction_decode;
  import instruction_decode_pkg::*;

  logic        clk;
  logic        rst;
  logic        instruction_valid;
  logic [31:0] pc_in;
  logic [31:0] inst;
  logic        action;
  logic [2:0]  dIType;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_itype;
  logic [31:0] out_pc;
  logic [31:0] out_header;
  logic [31:0] out_data;
  logic        halted;
  logic        err_overflow;
`ifdef INSTRUCTION_DECODE_STATS_EN
  logic [31:0] stat_decoded;
  logic [31:0] stat_stall;
`endif

  int checks = 0;
  int errors = 0;
  int fed;

  instruction_decode #(.INSTRUCTION_WIDTH(32), .DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .instruction_valid (instruction_valid),
    .pc_in             (pc_in),
    .inst              (inst),
    .action            (action),
    .dIType            (dIType),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_itype         (out_itype),
    .out_pc            (out_pc),
    .out_header        (out_header),
    .out_data          (out_data),
    .halted            (halted),
    .err_overflow      (err_overflow)
`ifdef INSTRUCTION_DECODE_STATS_EN
    ,
    .stat_decoded      (stat_decoded),
    .stat_stall        (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one word for two consecutive cycles, returning at the negedge after both
  task automatic drive(input logic [31:0] p, input logic [31:0] w);
    instruction_valid = 1'b1;
    pc_in = p;
    inst  = w;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    instruction_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [2:0] t, input logic [31:0] p,
                          input logic [31:0] h, input logic [31:0] d);
    chk({tag, "_valid"},  32'(out_valid),  32'd1);
    chk({tag, "_itype"},  32'(out_itype),  32'(t));
    chk({tag, "_pc"},     out_pc,          p);
    chk({tag, "_header"}, out_header,      h);
    chk({tag, "_data"},   out_data,        d);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_action"},  32'(action),       32'(fetchStall));
    chk({tag, "_ditype"},  32'(dIType),       32'(opRender));
    chk({tag, "_valid"},   32'(out_valid),    32'd0);
    chk({tag, "_itype"},   32'(out_itype),    32'd0);
    chk({tag, "_pc"},      out_pc,            32'd0);
    chk({tag, "_header"},  out_header,        32'd0);
    chk({tag, "_data"},    out_data,          32'd0);
    chk({tag, "_halted"},  32'(halted),       32'd0);
    chk({tag, "_ovf"},     32'(err_overflow), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    instruction_valid = 1'b0;
    pc_in = '0;
    inst = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values("init");
    release_reset();
    chk("first_action", 32'(action), 32'(fetchDequeue));

    // Duplicate presentations collapse to one push each
    drive(32'd0, 32'h2);
    chk_head("cam0", opCameraSet, 32'd0, 32'h2, 32'h0);
    drive(32'd1, 32'h4);
    chk_head("cam0_held", opCameraSet, 32'd0, 32'h2, 32'h0);
    out_ready = 1'b1;
    idle_cycle();
    chk_head("rend1", opRender, 32'd1, 32'h4, 32'h0);
    idle_cycle();
    chk("dedupe_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // ShapeSet pair, data word of zero is data not End
    chk("ss_ditype_before", 32'(dIType), 32'(opRender));
    drive(32'd2, 32'h1);
    chk("ss_ditype_data", 32'(dIType), 32'(opShapeSet));
    chk("ss_no_early_push", 32'(out_valid), 32'd0);
    drive(32'd3, 32'h0);
    chk("ss_ditype_after", 32'(dIType), 32'(opRender));
    chk("ss_not_halted", 32'(halted), 32'd0);
    chk_head("ss", opShapeSet, 32'd2, 32'h1, 32'h0);
    out_ready = 1'b1;
    idle_cycle();
    chk("ss_single_entry", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Loop word is not pushed and re-arms acceptance of a repeated address
    drive(32'd5, 32'h600);
    chk("loop_not_pushed", 32'(out_valid), 32'd0);
    drive(32'd5, 32'h2);
    chk_head("loop_repc", opCameraSet, 32'd5, 32'h2, 32'h0);
    drive(32'd1, 32'h4);
    out_ready = 1'b1;
    instruction_valid = 1'b0;
    chk_head("loop_first", opCameraSet, 32'd5, 32'h2, 32'h0);
    idle_cycle();
    chk_head("loop_pc1", opRender, 32'd1, 32'h4, 32'h0);
    idle_cycle();
    chk("loop_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Fetch obeying action: credit stops it after seven words, no overflow
    fed = 0;
    for (int k = 0; k < 12; k++) begin
      if (action != fetchDequeue) break;
      drive(32'(16 + k), 32'h3);
      fed++;
    end
    instruction_valid = 1'b0;
    chk("credit_fed", 32'(fed), 32'd7);
    chk("credit_stall", 32'(action), 32'(fetchStall));
    repeat (2) @(negedge clk);
    chk("credit_stall_hold", 32'(action), 32'(fetchStall));
    chk("credit_no_ovf", 32'(err_overflow), 32'd0);
    out_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      chk("credit_drain_valid", 32'(out_valid), 32'd1);
      chk("credit_drain_pc", out_pc, 32'(16 + j));
      @(negedge clk);
    end
    chk("credit_drain_empty", 32'(out_valid), 32'd0);
    chk("credit_resume", 32'(action), 32'(fetchDequeue));
    out_ready = 1'b0;

    // Ignoring action fills the FIFO; extra words are dropped and flagged
    for (int k = 0; k < 10; k++) drive(32'(32 + k), 32'h4);
    instruction_valid = 1'b0;
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("ovf_drain_valid", 32'(out_valid), 32'd1);
      chk("ovf_drain_pc", out_pc, 32'(32 + j));
      @(negedge clk);
    end
    chk("ovf_drain_empty", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(err_overflow), 32'd1);
    out_ready = 1'b0;

    // End halts decode; FIFO still drains; later words ignored
    drive(32'd6, 32'h0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_action", 32'(action), 32'(fetchStall));
    chk_head("end", opEnd, 32'd6, 32'h0, 32'h0);
    out_ready = 1'b1;
    drive(32'd7, 32'h2);
    chk("halt_drained", 32'(out_valid), 32'd0);
    drive(32'd8, 32'h1);
    chk("halt_ignored", 32'(out_valid), 32'd0);
    chk("halt_ditype", 32'(dIType), 32'(opRender));
    chk("halt_still", 32'(halted), 32'd1);
    chk("halt_action_hold", 32'(action), 32'(fetchStall));

    // Reset exits halt and restores reset values
    instruction_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_values("rst2");
    release_reset();
    chk("rst2_action", 32'(action), 32'(fetchDequeue));
    drive(32'd0, 32'h3);
    chk_head("post_rst", opLightSet, 32'd0, 32'h3, 32'h0);
    drive(32'd1, 32'h5);
    instruction_valid = 1'b0;
`ifdef INSTRUCTION_DECODE_STATS_EN
    chk("stat_decoded", stat_decoded, 32'd2);
    chk("stat_stall", stat_stall, 32'd0);
`endif
    out_ready = 1'b1;
    idle_cycle();
    chk_head("invalid_fwd", opInvalid, 32'd1, 32'h5, 32'h0);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
